sequenciador_bobc: RTL and testbench

SEQUENCIADOR_BOBC -- requirements
Module: sequenciador_bobc

---
 rtl/sequenciador_bobc.sv | 183 ++++++++++++++++++
 tb/tb_sequenciador_bobc.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_bobc.sv
// Sequencer for the controle/operativo pair: queues operand sets in a FIFO,
// launches one operation at a time, holds the result until consumed.
module sequenciador_bobc #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        ck,
  input  logic        rst,
  input  logic        wr,
  input  logic [7:0]  x_in,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  input  logic [15:0] c_in,
  output logic        full,
  output logic        inicio,
  output logic [7:0]  X,
  output logic [15:0] A,
  output logic [15:0] B,
  output logic [15:0] C,
  input  logic        done,
  input  logic [15:0] Resultado,
  output logic        res_valid,
  output logic [15:0] res_data,
  input  logic        res_ack,
  output logic        busy,
  output logic        erro
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = PW + 1;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int EW    = 56;

  typedef enum logic [1:0] {
    IDLE,
    LANCA,
    ESPERA,
    ENTREGA
  } state_t;

  state_t state_q, state_d;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [EW-1:0]    ops_q, ops_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic             res_valid_q, res_valid_d;
  logic [15:0]      res_data_q, res_data_d;
  logic             erro_q, erro_d;

  logic push;
  logic pop;
  logic capture;
  logic tmo_hit;
  logic full_int;

  // full is judged on pre-edge occupancy, so a pop on the same edge never frees room for wr
  always_comb begin
    full_int = (count_q == CNT_W'(DEPTH));
    push     = wr && !full_int;
    pop      = (state_q == IDLE) && (count_q != '0) && !erro_q;
    capture  = (state_q == ESPERA) && done;
    tmo_hit  = (state_q == ESPERA) && !done && (tmo_cnt_q == TW'(TIMEOUT - 1));
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    ops_d       = ops_q;
    tmo_cnt_d   = '0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    erro_d      = erro_q | tmo_hit;
    if (pop) begin
      ops_d = mem_q[rd_ptr_q];
    end
    if (state_q == ESPERA) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
    if (capture) begin
      res_data_d  = Resultado;
      res_valid_d = 1'b1;
    end else if (res_valid_q && res_ack) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge ck) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {x_in, a_in, b_in, c_in};
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ops_q       <= '0;
      tmo_cnt_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      erro_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ops_q       <= ops_d;
      tmo_cnt_q   <= tmo_cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      erro_q      <= erro_d;
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = LANCA;
        end
      end
      LANCA: begin
        state_d = ESPERA;
      end
      ESPERA: begin
        if (done) begin
          state_d = ENTREGA;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      ENTREGA: begin
        if (res_ack && res_valid_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    inicio    = (state_q == LANCA);
    busy      = (state_q != IDLE);
    full      = full_int;
    res_valid = res_valid_q;
    res_data  = res_data_q;
    erro      = erro_q;
    X         = ops_q[55:48];
    A         = ops_q[47:32];
    B         = ops_q[31:16];
    C         = ops_q[15:0];
  end

endmodule

// File: tb/tb_sequenciador_bobc.sv
// Scoreboard bench for sequenciador_bobc: directed operand sets with hand-computed
// results (A*X*X + B*X + C), a datapath responder and a result monitor.
module tb_sequenciador_bobc;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic        wr = 1'b0;
  logic [7:0]  x_in = '0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic [15:0] c_in = '0;
  logic        done = 1'b0;
  logic [15:0] Resultado = '0;
  logic        res_ack = 1'b0;
  logic        full;
  logic        inicio;
  logic [7:0]  X;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] C;
  logic        res_valid;
  logic [15:0] res_data;
  logic        busy;
  logic        erro;

  typedef struct {
    logic [7:0]  x;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] r;
  } op_t;

  op_t         op_q[$];
  logic [15:0] res_q[$];

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          done_cyc = -10;
  int          inicio_cnt = 0;
  int          dp_wait = 0;
  int          dp_delay = 4;
  bit          dp_enable = 1'b1;
  bit          stall = 1'b0;
  bit          have_cur = 1'b0;
  bit          inicio_prev = 1'b0;
  bit          rv_prev = 1'b0;
  op_t         cur;
  logic [15:0] dp_res = '0;
  logic [15:0] held_res = '0;

  sequenciador_bobc #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .ck        (ck),
    .rst       (rst),
    .wr        (wr),
    .x_in      (x_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .full      (full),
    .inicio    (inicio),
    .X         (X),
    .A         (A),
    .B         (B),
    .C         (C),
    .done      (done),
    .Resultado (Resultado),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ack   (res_ack),
    .busy      (busy),
    .erro      (erro)
  );

  always #5 ck = ~ck;

  always @(posedge ck) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s", name);
  endtask

  // Datapath stand-in: consumes the next expected operand set on each start pulse
  // and answers with its precomputed result after dp_delay cycles.
  always @(negedge ck) begin
    done = 1'b0;
    Resultado = 16'hBEEF;
    if (dp_wait > 0) begin
      dp_wait--;
      if (dp_wait == 0) begin
        done = 1'b1;
        Resultado = dp_res;
        done_cyc = cyc;
      end
    end
    if (!rst) have_cur = 1'b0;
    if (inicio) begin
      checkOutput("inicio_width", inicio_prev, 0);
      if (!inicio_prev) begin
        inicio_cnt++;
        if (op_q.size() == 0) begin
          reportFail("spurious_inicio");
        end else begin
          cur = op_q.pop_front();
          have_cur = 1'b1;
          if (dp_enable) begin
            dp_wait = dp_delay;
            dp_res = cur.r;
            res_q.push_back(cur.r);
          end
        end
      end
    end
    if (busy && have_cur) begin
      checkOutput("X_operand", X, cur.x);
      checkOutput("A_operand", A, cur.a);
      checkOutput("B_operand", B, cur.b);
      checkOutput("C_operand", C, cur.c);
    end
    inicio_prev = inicio;
  end

  // Result monitor and consumer: pops the scoreboard when a result appears.
  always @(negedge ck) begin
    if (res_valid && !rv_prev) begin
      checkOutput("done_to_valid_latency", done_cyc, cyc - 1);
      if (res_q.size() == 0) begin
        reportFail("unexpected_result");
      end else begin
        checkOutput("res_data", res_data, res_q.pop_front());
      end
      held_res = res_data;
    end else if (res_valid) begin
      checkOutput("res_data_stable", res_data, held_res);
    end
    res_ack = res_valid && !stall;
    rv_prev = res_valid;
  end

  task automatic applyStimulus(input logic [7:0] x, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] c, input logic [15:0] r,
                               input bit exp_accept, input bit track, input bit wait_space);
    op_t e;
    @(negedge ck); #1;
    if (wait_space) begin
      int guard = 0;
      while (full === 1'b1 && guard < 200) begin
        @(negedge ck); #1;
        guard++;
      end
    end
    checkOutput("accept", {31'b0, ~full}, {31'b0, exp_accept});
    x_in = x;
    a_in = a;
    b_in = b;
    c_in = c;
    wr = 1'b1;
    @(negedge ck); #1;
    wr = 1'b0;
    if (exp_accept && track) begin
      e = '{x, a, b, c, r};
      op_q.push_back(e);
    end
  endtask

  task automatic waitIdle(input string name);
    int g = 0;
    while (!(busy === 1'b0 && res_valid === 1'b0 && op_q.size() == 0 && res_q.size() == 0) && g < 500) begin
      @(negedge ck); #1;
      g++;
    end
    if (g >= 500) reportFail({name, "_drain_timeout"});
  endtask

  task automatic waitInicio(input string name);
    int g = 0;
    while (inicio !== 1'b1 && g < 100) begin
      @(negedge ck); #1;
      g++;
    end
    if (g >= 100) reportFail({name, "_inicio_timeout"});
  endtask

  task automatic waitValid(input string name);
    int g = 0;
    while (res_valid !== 1'b1 && g < 100) begin
      @(negedge ck); #1;
      g++;
    end
    if (g >= 100) reportFail({name, "_valid_timeout"});
  endtask

  logic [7:0]  wx [9] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
  logic [15:0] wr_exp [9] = '{16'hF005, 16'hF00F, 16'hF01D, 16'hF02F, 16'hF045,
                              16'hF05F, 16'hF07D, 16'hF09F, 16'hF0C5};

  initial begin
    int base;
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_full", full, 0);
    checkOutput("rst_inicio", inicio, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_erro", erro, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res_data", res_data, 0);
    checkOutput("rst_X", X, 0);
    @(negedge ck); #1 rst = 1'b1;

    $display("[TB] single operation");
    dp_delay = 4;
    applyStimulus(8'd3, 16'd1, 16'd2, 16'd5, 16'h0014, 1'b1, 1'b1, 1'b0);
    checkOutput("idle_before_launch", busy, 0);
    @(negedge ck); #1;
    checkOutput("inicio_latency", inicio, 1);
    waitIdle("single");
    checkOutput("single_inicio_count", inicio_cnt, 1);
    checkOutput("res_data_after_ack", res_data, 16'h0014);

    $display("[TB] full, drop and backpressure");
    stall = 1'b1;
    applyStimulus(8'd1, 16'd1, 16'd1, 16'd1, 16'h0003, 1'b1, 1'b1, 1'b0);
    waitValid("prime");
    applyStimulus(8'd2, 16'd3, 16'd4, 16'd5, 16'h0019, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'd4, 16'd0, 16'd10, 16'd7, 16'h002F, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'd5, 16'd2, 16'd0, 16'd100, 16'h0096, 1'b1, 1'b1, 1'b0);
    checkOutput("not_full_after_3", full, 0);
    applyStimulus(8'd10, 16'd1, 16'd1, 16'd0, 16'h006E, 1'b1, 1'b1, 1'b0);
    checkOutput("full_after_4", full, 1);
    applyStimulus(8'd7, 16'd7, 16'd7, 16'd7, 16'h018F, 1'b0, 1'b1, 1'b0);
    base = inicio_cnt;
    repeat (10) begin
      @(negedge ck); #1;
      checkOutput("stall_no_inicio", inicio, 0);
    end
    checkOutput("stall_inicio_count", inicio_cnt, base);
    checkOutput("full_held", full, 1);
    stall = 1'b0;
    @(negedge ck); #1;
    @(negedge ck); #1;
    checkOutput("ack_to_idle", busy, 0);
    x_in = 8'd9;
    a_in = 16'd9;
    b_in = 16'd9;
    c_in = 16'd9;
    wr = 1'b1;
    @(negedge ck); #1;
    wr = 1'b0;
    checkOutput("idle_to_inicio", inicio, 1);
    checkOutput("full_pop_drops_wr", full, 0);
    waitIdle("drop");
    checkOutput("drop_inicio_count", inicio_cnt, base + 4);

    $display("[TB] pointer wrap");
    dp_delay = 1;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(wx[i], 16'h0002, 16'h0003, 16'hF000 + 16'(i), wr_exp[i], 1'b1, 1'b1, 1'b1);
    end
    waitIdle("wrap");
    checkOutput("wrap_last_result", res_data, 16'hF0C5);

    $display("[TB] reset during wait");
    dp_delay = 10;
    applyStimulus(8'hA5, 16'h1234, 16'h5678, 16'h9ABC, 16'h0000, 1'b1, 1'b1, 1'b0);
    waitInicio("rstop");
    repeat (3) @(negedge ck);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_inicio", inicio, 0);
    checkOutput("arst_X", X, 0);
    checkOutput("arst_A", A, 0);
    checkOutput("arst_C", C, 0);
    checkOutput("arst_res_data", res_data, 0);
    checkOutput("arst_res_valid", res_valid, 0);
    op_q.delete();
    res_q.delete();
    @(negedge ck); #1;
    @(negedge ck); #3 rst = 1'b1;
    repeat (12) @(negedge ck);
    #1;
    checkOutput("late_done_ignored", res_valid, 0);
    checkOutput("late_done_busy", busy, 0);

    $display("[TB] timeout");
    dp_enable = 1'b0;
    applyStimulus(8'd2, 16'h0100, 16'h0010, 16'h0001, 16'h0421, 1'b1, 1'b1, 1'b0);
    waitInicio("tmo");
    repeat (TIMEOUT) @(negedge ck);
    #1;
    checkOutput("erro_before_timeout", erro, 0);
    checkOutput("busy_before_timeout", busy, 1);
    @(negedge ck); #1;
    checkOutput("erro_at_timeout", erro, 1);
    checkOutput("idle_after_timeout", busy, 0);
    checkOutput("no_result_on_timeout", res_valid, 0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(8'(i), 16'(i), 16'(i), 16'(i), 16'h0000, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("erro_fifo_fills", full, 1);
    repeat (5) begin
      @(negedge ck); #1;
      checkOutput("erro_no_inicio", inicio, 0);
    end
    checkOutput("erro_sticky", erro, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
